hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Hazard/forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Tracks each in-flight destination register and its remaining production time (Tnew) through E, M and W.
- Drives the 2-bit select inputs of the 3-way forwarding muxes in D and E, the 1-bit store-data select in M, and the D-stage stall.
- Every select value it issues is 00, 01 or 10 (register file / M-stage result / W-stage result); 11 is never driven.

Parameters:
- REG_AW, 5, register address width; address 0 is the hardwired zero register.
- TW, 2, width of the Tnew/Tuse fields.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); clears all tracked state immediately.
- d_rs  input  REG_AW  rs index of the instruction in D.
- d_rt  input  REG_AW  rt index of the instruction in D.
- d_rs_tuse  input  TW  cycles until D needs rs (0 = branch compare in D, 1 = E ALU, 2 = M store; 3 = rs unused).
- d_rt_tuse  input  TW  same encoding for rt.
- d_dst  input  REG_AW  destination of the D instruction; 0 = no write.
- d_tnew  input  TW  cycles after entering E until the result is forwardable (0 = lui/jal, 1 = ALU, 2 = load).
- stall  output  1  freeze F/D and insert a bubble into E.
- fwd_rs_d_sel  output  2  D-stage rs mux select.
- fwd_rt_d_sel  output  2  D-stage rt mux select.
- fwd_rs_e_sel  output  2  E-stage rs mux select.
- fwd_rt_e_sel  output  2  E-stage rt mux select.
- fwd_rt_m_sel  output  1  M-stage store-data select (1 = W result).

Behaviour:
- State: three stage records, E{rs, rt, dst, tnew}, M{rt, dst, tnew}, W{dst}. A record with dst = 0 never matches any operand.
- Reset (reset = 0, asynchronous): all fields = 0. All outputs are combinational from state and inputs, so reset gives stall = 0 and every select = 0.
- Rising edge, stall = 0:
  - E ← {d_rs, d_rt, d_dst, d_tnew}.
  - M ← {E.rt, E.dst, max(E.tnew − 1, 0)}.
  - W ← M.dst.
- Rising edge, stall = 1: E ← all zeros (bubble). M and W advance exactly as above.
- Stall (combinational). For each operand op ∈ {rs, rt} with op ≠ 0 and tuse ≠ 3, a hazard exists when either:
  - E.dst == op and E.tnew > tuse, or
  - M.dst == op and M.tnew > tuse.
  - stall = OR over both operands.
- M-stage tnew is forwardable only when it equals 0; a W result is always forwardable.
- D select, per operand op (computed even when stall = 1; do not gate):
  - 01 if op ≠ 0, M.dst == op and M.tnew == 0;
  - else 10 if op ≠ 0 and W.dst == op;
  - else 00.
  - M has priority over W (youngest producer wins).
- E select: same rule using E.rs / E.rt against M and W.
- fwd_rt_m_sel = 1 iff M.rt ≠ 0 and W.dst == M.rt.
- Producers still in E are never forwarded; such cases are covered by stall.
- Back-to-back writes to the same register: the youngest matching stage wins.
- Asserting reset mid-stall clears the bubble logic; the first cycle after release has stall = 0.

Test Plan:
- Reset low with random inputs -> stall = 0 and all selects 00; hold reset low across clk edges -> still 0.
- ALU writes $8 (d_dst = 8, d_tnew = 1); next cycle D uses $8 as rs with tuse 1 -> stall = 0; one cycle later fwd_rs_e_sel = 01; the following cycle (producer in W), an E instruction reading $8 gets 10.
- Load to $9 (d_tnew = 2), then an ALU op reading $9 (tuse 1) -> stall = 1 for exactly 1 cycle, E bubble; after the stall, fwd_rs_e_sel = 10.
- ALU to $5, then a beq reading rs = $5 (tuse 0) -> stall = 1 for 1 cycle, then fwd_rs_d_sel = 01, stall = 0.
- Two ALU writes to $3 back-to-back, then a consumer of $3 -> E select 01 (younger producer), not 10.
- Writes to $0 followed by reads of $0 -> no stall, all selects 00. lw $4 then sw with rt = $4 (rt tuse 2) -> no stall, fwd_rt_m_sel = 1 when sw is in M.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage operand info into the hazard/forwarding controller and the
// stall/mux selects it returns to the pipeline.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) ();
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_rs_tuse;
  logic [TW-1:0]     d_rt_tuse;
  logic [REG_AW-1:0] d_dst;
  logic [TW-1:0]     d_tnew;
  logic              stall;
  logic [1:0]        fwd_rs_d_sel;
  logic [1:0]        fwd_rt_d_sel;
  logic [1:0]        fwd_rs_e_sel;
  logic [1:0]        fwd_rt_e_sel;
  logic              fwd_rt_m_sel;

  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
    input  stall, fwd_rs_d_sel, fwd_rt_d_sel, fwd_rs_e_sel, fwd_rt_e_sel, fwd_rt_m_sel
  );

  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
    output stall, fwd_rs_d_sel, fwd_rt_d_sel, fwd_rs_e_sel, fwd_rt_e_sel, fwd_rt_m_sel
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Tnew/Tuse hazard and forwarding controller for a 5-stage F/D/E/M/W pipeline.
// Tracks producers in E, M and W; stalls D when a value cannot arrive in time.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  hazard_fwd_ctrl_if.slave bus
);

  localparam logic [1:0]        SEL_RF = 2'b00;
  localparam logic [1:0]        SEL_M  = 2'b01;
  localparam logic [1:0]        SEL_W  = 2'b10;
  localparam logic [TW-1:0]     TUSE_NONE = {TW{1'b1}};
  localparam logic [REG_AW-1:0] REG_ZERO  = '0;

  logic [REG_AW-1:0] e_rs_q, e_rs_d;
  logic [REG_AW-1:0] e_rt_q, e_rt_d;
  logic [REG_AW-1:0] e_dst_q, e_dst_d;
  logic [TW-1:0]     e_tnew_q, e_tnew_d;
  logic [REG_AW-1:0] m_rt_q, m_rt_d;
  logic [REG_AW-1:0] m_dst_q, m_dst_d;
  logic [TW-1:0]     m_tnew_q, m_tnew_d;
  logic [REG_AW-1:0] w_dst_q, w_dst_d;

  logic stall_c;

  // A value is needed too early if its producer still needs more cycles than the consumer can wait.
  function automatic logic hazard(
    input logic [REG_AW-1:0] op,
    input logic [TW-1:0]     tuse,
    input logic [REG_AW-1:0] e_dst,
    input logic [TW-1:0]     e_tnew,
    input logic [REG_AW-1:0] m_dst,
    input logic [TW-1:0]     m_tnew
  );
    logic h;
    h = 1'b0;
    if (op != REG_ZERO && tuse != TUSE_NONE) begin
      h = ((e_dst == op) && (e_tnew > tuse)) ||
          ((m_dst == op) && (m_tnew > tuse));
    end
    return h;
  endfunction

  // Youngest forwardable producer wins: M (only once its result is ready) before W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] op,
    input logic [REG_AW-1:0] m_dst,
    input logic [TW-1:0]     m_tnew,
    input logic [REG_AW-1:0] w_dst
  );
    logic [1:0] s;
    s = SEL_RF;
    if (op != REG_ZERO) begin
      if (m_dst == op && m_tnew == '0) begin
        s = SEL_M;
      end else if (w_dst == op) begin
        s = SEL_W;
      end
    end
    return s;
  endfunction

  always_comb begin
    stall_c = hazard(bus.d_rs, bus.d_rs_tuse, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) |
              hazard(bus.d_rt, bus.d_rt_tuse, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
  end

  assign bus.stall        = stall_c;
  assign bus.fwd_rs_d_sel = fwd_sel(bus.d_rs, m_dst_q, m_tnew_q, w_dst_q);
  assign bus.fwd_rt_d_sel = fwd_sel(bus.d_rt, m_dst_q, m_tnew_q, w_dst_q);
  assign bus.fwd_rs_e_sel = fwd_sel(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
  assign bus.fwd_rt_e_sel = fwd_sel(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
  assign bus.fwd_rt_m_sel = (m_rt_q != REG_ZERO) && (w_dst_q == m_rt_q);

  always_comb begin
    e_rs_d   = bus.d_rs;
    e_rt_d   = bus.d_rt;
    e_dst_d  = bus.d_dst;
    e_tnew_d = bus.d_tnew;
    // A stalled D instruction stays put; E receives a bubble instead.
    if (stall_c) begin
      e_rs_d   = '0;
      e_rt_d   = '0;
      e_dst_d  = '0;
      e_tnew_d = '0;
    end
    m_rt_d   = e_rt_q;
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TW'(1);
    w_dst_d  = m_dst_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_dst_q  <= '0;
      e_tnew_q <= '0;
      m_rt_q   <= '0;
      m_dst_q  <= '0;
      m_tnew_q <= '0;
      w_dst_q  <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_rt_q   <= m_rt_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scenario bench for hazard_fwd_ctrl: each D-stage instruction pushes its
// hand-derived expected outputs, which are popped and compared mid-cycle.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic reset;

  hazard_fwd_ctrl_if #(.REG_AW(5), .TW(2)) bus ();

  hazard_fwd_ctrl #(.REG_AW(5), .TW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {stall, rs_d, rt_d, rs_e, rt_e, rt_m}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [9:0] exp;
  } row_t;

  logic [9:0] sb[$];
  logic [9:0] obs;
  logic [9:0] want;
  int checks = 0;
  int errors = 0;

  assign obs = {bus.stall, bus.fwd_rs_d_sel, bus.fwd_rt_d_sel,
                bus.fwd_rs_e_sel, bus.fwd_rt_e_sel, bus.fwd_rt_m_sel};

  function automatic row_t mk(input int rs, input int rt, input int rs_tuse, input int rt_tuse,
                              input int dst, input int tnew, input logic [9:0] exp);
    row_t r;
    r.rs      = 5'(rs);
    r.rt      = 5'(rt);
    r.rs_tuse = 2'(rs_tuse);
    r.rt_tuse = 2'(rt_tuse);
    r.dst     = 5'(dst);
    r.tnew    = 2'(tnew);
    r.exp     = exp;
    return r;
  endfunction

  function automatic row_t nop(input logic [9:0] exp);
    return mk(0, 0, 3, 3, 0, 0, exp);
  endfunction

  task automatic apply(input row_t r);
    bus.d_rs      = r.rs;
    bus.d_rt      = r.rt;
    bus.d_rs_tuse = r.rs_tuse;
    bus.d_rt_tuse = r.rt_tuse;
    bus.d_dst     = r.dst;
    bus.d_tnew    = r.tnew;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      bus.d_rs      = 5'($urandom);
      bus.d_rt      = 5'($urandom);
      bus.d_rs_tuse = 2'($urandom);
      bus.d_rt_tuse = 2'($urandom);
      bus.d_dst     = 5'($urandom);
      bus.d_tnew    = 2'($urandom);
      sb.push_back(10'b0);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, want);
      end
      $display("reset[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
    reset = 1'b1;
  endtask

  task automatic test_alu_forward;
    row_t rows[4];
    rows[0] = mk(0, 0, 3, 3, 8, 1, 10'b0);
    rows[1] = mk(8, 0, 1, 3, 0, 0, 10'b0);
    rows[2] = mk(8, 0, 1, 3, 0, 0, 10'b0_01_00_01_00_0);
    rows[3] = nop(10'b0_00_00_10_00_0);
    for (int i = 0; i < 4; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL alu_forward[%0d]: got %b want %b", i, obs, want);
      end
      $display("alu_forward[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use;
    row_t rows[4];
    rows[0] = mk(0, 0, 3, 3, 9, 2, 10'b0);
    rows[1] = mk(9, 0, 1, 3, 0, 0, 10'b1_00_00_00_00_0);
    rows[2] = mk(9, 0, 1, 3, 0, 0, 10'b0);
    rows[3] = nop(10'b0_00_00_10_00_0);
    for (int i = 0; i < 4; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, want);
      end
      $display("load_use[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    row_t rows[5];
    rows[0] = mk(0, 0, 3, 3, 5, 1, 10'b0);
    rows[1] = mk(5, 0, 0, 3, 0, 0, 10'b1_00_00_00_00_0);
    rows[2] = mk(5, 0, 0, 3, 0, 0, 10'b0_01_00_00_00_0);
    rows[3] = nop(10'b0_00_00_10_00_0);
    rows[4] = nop(10'b0);
    for (int i = 0; i < 5; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs, want);
      end
      $display("branch[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[5];
    rows[0] = mk(0, 0, 3, 3, 3, 1, 10'b0);
    rows[1] = mk(0, 0, 3, 3, 3, 1, 10'b0);
    rows[2] = mk(3, 0, 1, 3, 0, 0, 10'b0_01_00_00_00_0);
    rows[3] = nop(10'b0_00_00_01_00_0);
    rows[4] = nop(10'b0);
    for (int i = 0; i < 5; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, want);
      end
      $display("back_to_back[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rt_paths;
    row_t rows[6];
    rows[0] = mk(0, 0, 3, 3, 7, 1, 10'b0);
    rows[1] = nop(10'b0);
    rows[2] = mk(0, 7, 3, 1, 0, 0, 10'b0_00_01_00_00_0);
    rows[3] = mk(0, 7, 3, 1, 0, 0, 10'b0_00_10_00_10_0);
    rows[4] = nop(10'b0);
    rows[5] = nop(10'b0);
    for (int i = 0; i < 6; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL rt_paths[%0d]: got %b want %b", i, obs, want);
      end
      $display("rt_paths[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_store;
    row_t rows[8];
    rows[0] = mk(0, 0, 3, 3, 0, 2, 10'b0);
    rows[1] = mk(0, 0, 0, 0, 0, 0, 10'b0);
    rows[2] = nop(10'b0);
    rows[3] = mk(0, 0, 3, 3, 4, 2, 10'b0);
    rows[4] = mk(0, 4, 1, 2, 0, 0, 10'b0);
    rows[5] = nop(10'b0);
    rows[6] = nop(10'b0_00_00_00_00_1);
    rows[7] = nop(10'b0);
    for (int i = 0; i < 8; i++) begin
      apply(rows[i]);
      #2;
      want = sb.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL zero_store[%0d]: got %b want %b", i, obs, want);
      end
      $display("zero_store[%0d] out=%b", i, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall;
    apply(mk(0, 0, 3, 3, 9, 2, 10'b0));
    #2;
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_stall_load: got %b want %b", obs, want);
    end
    @(posedge clk); #1;
    apply(mk(9, 0, 1, 3, 0, 0, 10'b1_00_00_00_00_0));
    #2;
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_stall_before: got %b want %b", obs, want);
    end
    $display("rst_stall before reset out=%b", obs);
    reset = 1'b0;
    sb.push_back(10'b0);
    #1;
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_stall_async: got %b want %b", obs, want);
    end
    $display("rst_stall during reset out=%b", obs);
    @(posedge clk); #1;
    reset = 1'b1;
    apply(mk(9, 0, 1, 3, 0, 0, 10'b0));
    #2;
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_stall_after: got %b want %b", obs, want);
    end
    $display("rst_stall after release out=%b", obs);
    @(posedge clk); #1;
    apply(nop(10'b0));
    #2;
    want = sb.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_stall_drain: got %b want %b", obs, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.d_rs      = '0;
    bus.d_rt      = '0;
    bus.d_rs_tuse = 2'd3;
    bus.d_rt_tuse = 2'd3;
    bus.d_dst     = '0;
    bus.d_tnew    = '0;
    #1;
    test_reset;
    test_alu_forward;
    test_load_use;
    test_branch;
    test_back_to_back;
    test_rt_paths;
    test_zero_and_store;
    test_reset_mid_stall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
